// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired-zero x0, two combinational read ports,
// one synchronous write port, a per-register busy scoreboard and optional write bypass.
module regfile_sb #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic             rs1_busy,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs2_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    output logic             claim_ok,
    output logic [DEPTH-1:0] busy_vec
);

    // Entry 0 of both arrays is only ever reset, so x0 stays zero and never busy.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_d;
    logic             w_claim_ok;
    logic             w_bypass1;
    logic             w_bypass2;

    always_comb begin
        w_claim_ok = 1'b0;
        if (reset && claim_en) begin
            w_claim_ok = (claim_addr == '0) || !r_busy[claim_addr] ||
                         (wr_en && (wr_addr == claim_addr));
        end
    end

    // A claim landing on the same edge as a completing write wins: busy ends set.
    always_comb begin
        w_busy_d = r_busy;
        for (int i = 1; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) w_busy_d[i] = 1'b0;
            if (w_claim_ok && (claim_addr == AW'(i))) w_busy_d[i] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en && (wr_addr == AW'(i))) r_mem[i] <= wr_data;
            end
            r_busy <= w_busy_d;
        end
    end

    assign w_bypass1 = (BYPASS != 0) && reset && wr_en && (wr_addr == rs1_addr);
    assign w_bypass2 = (BYPASS != 0) && reset && wr_en && (wr_addr == rs2_addr);

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            if (w_bypass1) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = r_mem[rs1_addr];
                rs1_busy = r_busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            if (w_bypass2) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = r_mem[rs2_addr];
                rs2_busy = r_busy[rs2_addr];
            end
        end
    end

    assign claim_ok = w_claim_ok;
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a BYPASS=0 build and a 16x32 build
// checked against a small reference model under random traffic.
module tb_regfile_sb;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default build (6 x 8, bypass on)
    logic [2:0] a_rs1_addr, a_rs2_addr, a_wr_addr, a_claim_addr;
    logic [5:0] a_rs1_data, a_rs2_data, a_wr_data;
    logic       a_rs1_busy, a_rs2_busy, a_wr_en, a_claim_en, a_claim_ok;
    logic [7:0] a_busy_vec;

    regfile_sb u_dut (
        .clk(clk), .reset(reset),
        .rs1_addr(a_rs1_addr), .rs1_data(a_rs1_data), .rs1_busy(a_rs1_busy),
        .rs2_addr(a_rs2_addr), .rs2_data(a_rs2_data), .rs2_busy(a_rs2_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .claim_en(a_claim_en), .claim_addr(a_claim_addr), .claim_ok(a_claim_ok),
        .busy_vec(a_busy_vec)
    );

    // No-bypass build
    logic [2:0] b_rs1_addr, b_rs2_addr, b_wr_addr, b_claim_addr;
    logic [5:0] b_rs1_data, b_rs2_data, b_wr_data;
    logic       b_rs1_busy, b_rs2_busy, b_wr_en, b_claim_en, b_claim_ok;
    logic [7:0] b_busy_vec;

    regfile_sb #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset),
        .rs1_addr(b_rs1_addr), .rs1_data(b_rs1_data), .rs1_busy(b_rs1_busy),
        .rs2_addr(b_rs2_addr), .rs2_data(b_rs2_data), .rs2_busy(b_rs2_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .claim_en(b_claim_en), .claim_addr(b_claim_addr), .claim_ok(b_claim_ok),
        .busy_vec(b_busy_vec)
    );

    // Wide build (16 x 32)
    logic [4:0]  w_rs1_addr, w_rs2_addr, w_wr_addr, w_claim_addr;
    logic [15:0] w_rs1_data, w_rs2_data, w_wr_data;
    logic        w_rs1_busy, w_rs2_busy, w_wr_en, w_claim_en, w_claim_ok;
    logic [31:0] w_busy_vec;

    regfile_sb #(.WIDTH(16), .DEPTH(32)) u_dut_w (
        .clk(clk), .reset(reset),
        .rs1_addr(w_rs1_addr), .rs1_data(w_rs1_data), .rs1_busy(w_rs1_busy),
        .rs2_addr(w_rs2_addr), .rs2_data(w_rs2_data), .rs2_busy(w_rs2_busy),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .claim_en(w_claim_en), .claim_addr(w_claim_addr), .claim_ok(w_claim_ok),
        .busy_vec(w_busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the wide build
    logic [15:0] m_mem [32];
    logic [31:0] m_busy;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        {a_rs1_addr, a_rs2_addr, a_wr_addr, a_claim_addr, a_wr_data} = '0;
        {a_wr_en, a_claim_en} = '0;
        {b_rs1_addr, b_rs2_addr, b_wr_addr, b_claim_addr, b_wr_data} = '0;
        {b_wr_en, b_claim_en} = '0;
        {w_rs1_addr, w_rs2_addr, w_wr_addr, w_claim_addr, w_wr_data} = '0;
        {w_wr_en, w_claim_en} = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;

        // Reset then read every address on both ports
        #3;
        check("rst_busy_vec_low", a_busy_vec, 8'h00);
        check("rst_claim_ok_low", a_claim_ok, 1'b0);
        step();
        #2 reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            a_rs1_addr = 3'(a);
            a_rs2_addr = 3'(7 - a);
            #1;
            check("rst_rs1_data", a_rs1_data, 6'h00);
            check("rst_rs1_busy", a_rs1_busy, 1'b0);
            check("rst_rs2_data", a_rs2_data, 6'h00);
            check("rst_rs2_busy", a_rs2_busy, 1'b0);
        end
        check("rst_busy_vec", a_busy_vec, 8'h00);
        step();

        // Write x3 with same-cycle bypass, then a discarded write to x0
        a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 6'h2A; a_rs1_addr = 3'd3;
        #1 check("bypass_x3", a_rs1_data, 6'h2A);
        check("bypass_x3_busy", a_rs1_busy, 1'b0);
        step();
        a_wr_addr = 3'd0; a_wr_data = 6'h3F; a_rs2_addr = 3'd0;
        #1 check("wr_x0_bypass", a_rs2_data, 6'h00);
        step();
        a_wr_en = 1'b0;
        #1 check("rd_x3", a_rs1_data, 6'h2A);
        check("rd_x0", a_rs2_data, 6'h00);

        // Scoreboard: claim, reject, complete
        a_claim_en = 1'b1; a_claim_addr = 3'd5;
        #1 check("claim_x5_ok", a_claim_ok, 1'b1);
        step();
        a_claim_en = 1'b0; a_rs2_addr = 3'd5;
        #1 check("busy_vec_x5", a_busy_vec, 8'h20);
        check("rs2_busy_x5", a_rs2_busy, 1'b1);
        a_claim_en = 1'b1;
        #1 check("claim_x5_reject", a_claim_ok, 1'b0);
        a_claim_en = 1'b1; a_claim_addr = 3'd0;
        #1 check("claim_x0_ok", a_claim_ok, 1'b1);
        step();
        a_claim_en = 1'b0;
        #1 check("busy_after_reject", a_busy_vec, 8'h20);
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 6'h11;
        step();
        a_wr_en = 1'b0; a_rs1_addr = 3'd5;
        #1 check("x5_done_data", a_rs1_data, 6'h11);
        check("x5_done_busy", a_rs1_busy, 1'b0);
        check("x5_done_vec", a_busy_vec, 8'h00);

        // Simultaneous write and claim of busy x5
        a_claim_en = 1'b1; a_claim_addr = 3'd5;
        step();
        a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 6'h22;
        #1 check("wc_claim_ok", a_claim_ok, 1'b1);
        check("wc_bypass_data", a_rs1_data, 6'h22);
        check("wc_bypass_busy", a_rs1_busy, 1'b0);
        step();
        a_wr_en = 1'b0; a_claim_en = 1'b0;
        #1 check("wc_data", a_rs1_data, 6'h22);
        check("wc_busy", a_rs1_busy, 1'b1);
        check("wc_vec", a_busy_vec, 8'h20);

        // No-bypass build: old value in the write cycle, new value after
        b_wr_en = 1'b1; b_wr_addr = 3'd2; b_wr_data = 6'h05; b_rs1_addr = 3'd2;
        step();
        b_wr_data = 6'h07;
        #1 check("nb_old", b_rs1_data, 6'h05);
        step();
        b_wr_en = 1'b0;
        #1 check("nb_new", b_rs1_data, 6'h07);

        // Reset pulse between edges
        a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 6'h15;
        a_claim_en = 1'b1; a_claim_addr = 3'd1; a_rs1_addr = 3'd1;
        step();
        a_wr_en = 1'b0; a_claim_en = 1'b0;
        #1 check("pre_rst_data", a_rs1_data, 6'h15);
        check("pre_rst_busy", a_rs1_busy, 1'b1);
        #1 reset = 1'b0;
        #1 check("mid_rst_data", a_rs1_data, 6'h00);
        check("mid_rst_vec", a_busy_vec, 8'h00);
        #1 reset = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 3'd1; a_wr_data = 6'h09;
        step();
        a_wr_en = 1'b0;
        #1 check("post_rst_wr", a_rs1_data, 6'h09);
        check("post_rst_vec", a_busy_vec, 8'h00);

        // Wide build: random traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [15:0] e_d1, e_d2;
            logic        e_b1, e_b2, e_ok;
            w_wr_en      = 1'($urandom_range(0, 1));
            w_wr_addr    = 5'($urandom_range(0, 31));
            w_wr_data    = 16'($urandom);
            w_claim_en   = 1'($urandom_range(0, 1));
            w_claim_addr = (n % 4 == 0) ? w_wr_addr : 5'($urandom_range(0, 31));
            w_rs1_addr   = (n % 3 == 0) ? w_wr_addr : 5'($urandom_range(0, 31));
            w_rs2_addr   = (n % 5 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            #1;
            e_d1 = m_mem[w_rs1_addr]; e_b1 = m_busy[w_rs1_addr];
            if (w_wr_en && w_wr_addr == w_rs1_addr) begin e_d1 = w_wr_data; e_b1 = 1'b0; end
            if (w_rs1_addr == 5'd0) begin e_d1 = '0; e_b1 = 1'b0; end
            e_d2 = m_mem[w_rs2_addr]; e_b2 = m_busy[w_rs2_addr];
            if (w_wr_en && w_wr_addr == w_rs2_addr) begin e_d2 = w_wr_data; e_b2 = 1'b0; end
            if (w_rs2_addr == 5'd0) begin e_d2 = '0; e_b2 = 1'b0; end
            e_ok = w_claim_en && (w_claim_addr == 5'd0 || !m_busy[w_claim_addr] ||
                                  (w_wr_en && w_wr_addr == w_claim_addr));
            check("w_rs1_data", w_rs1_data, e_d1);
            check("w_rs1_busy", w_rs1_busy, e_b1);
            check("w_rs2_data", w_rs2_data, e_d2);
            check("w_rs2_busy", w_rs2_busy, e_b2);
            check("w_claim_ok", w_claim_ok, e_ok);
            check("w_busy_vec", w_busy_vec, m_busy);
            if (w_wr_en && w_wr_addr != 5'd0) begin
                m_mem[w_wr_addr]  = w_wr_data;
                m_busy[w_wr_addr] = 1'b0;
            end
            if (e_ok && w_claim_addr != 5'd0) m_busy[w_claim_addr] = 1'b1;
            step();
        end
        w_wr_en = 1'b0; w_claim_en = 1'b0;
        #1 check("w_final_vec", w_busy_vec, m_busy);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
